// File: rtl/rf_scoreboard.sv
// Register file with a per-register pending bit for operand hazard tracking.
// Writeback clears pending, issue sets it, and reads can forward same-cycle writeback data.
module rf_scoreboard #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 8,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_addr,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  rd_en1,
    input  logic [AW-1:0]         rd_addr1,
    input  logic                  rd_en2,
    input  logic [AW-1:0]         rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic                  rd_ready1,
    output logic                  rd_ready2,
    output logic                  stall,
    output logic [AW:0]           pending_count
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0]  pending;
    logic                  wb_ok;
    logic                  issue_ok;
    logic                  zero1, zero2;
    logic                  fwd1, fwd2;

    // Writes and issues aimed at the hardwired zero register are dropped.
    always_comb begin
        wb_ok    = wb_en    && !((ZERO_REG != 0) && (wb_addr    == '0));
        issue_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));
    end

    // Register array and pending bits; an issue to the written address wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else begin
            if (wb_ok) begin
                regs[wb_addr]    <= wb_data;
                pending[wb_addr] <= 1'b0;
            end
            if (issue_ok) begin
                pending[issue_addr] <= 1'b1;
            end
        end
    end

    // Read port 1: zero register, then forwarded writeback, then stored value.
    always_comb begin
        zero1     = (ZERO_REG != 0) && (rd_addr1 == '0);
        fwd1      = (BYPASS != 0) && wb_en && (wb_addr == rd_addr1) && !zero1;
        rd_data1  = zero1 ? '0 : (fwd1 ? wb_data : regs[rd_addr1]);
        rd_ready1 = zero1 || !pending[rd_addr1] || fwd1;
    end

    // Read port 2: identical to port 1, fully independent.
    always_comb begin
        zero2     = (ZERO_REG != 0) && (rd_addr2 == '0);
        fwd2      = (BYPASS != 0) && wb_en && (wb_addr == rd_addr2) && !zero2;
        rd_data2  = zero2 ? '0 : (fwd2 ? wb_data : regs[rd_addr2]);
        rd_ready2 = zero2 || !pending[rd_addr2] || fwd2;
    end

    // Hazard whenever an in-use operand is not ready.
    always_comb begin
        stall = (rd_en1 && !rd_ready1) || (rd_en2 && !rd_ready2);
    end

    // Population count of the registered pending vector only.
    always_comb begin
        pending_count = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            pending_count = pending_count + (AW + 1)'(pending[i]);
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: a bypass and a non-bypass instance share stimulus;
// expected outputs come from a reference model and flow through a queue.
module tb_rf_scoreboard;

    localparam int DW = 8;
    localparam int RC = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_en;
    logic [AW-1:0] issue_addr;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          rd_en1, rd_en2;
    logic [AW-1:0] rd_addr1, rd_addr2;

    logic [DW-1:0] rd_data1 [2];
    logic [DW-1:0] rd_data2 [2];
    logic          rd_ready1 [2];
    logic          rd_ready2 [2];
    logic          stall [2];
    logic [AW:0]   pending_count [2];

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        string       tag;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic        r1;
        logic        r2;
        logic        st;
        logic [3:0]  cnt;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] mregs [RC];
    logic [RC-1:0] mpend;

    always #5 clk = ~clk;

    rf_scoreboard #(.DATA_WIDTH(DW), .REG_COUNT(RC), .ZERO_REG(1), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_en2(rd_en2), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1[0]), .rd_data2(rd_data2[0]),
        .rd_ready1(rd_ready1[0]), .rd_ready2(rd_ready2[0]),
        .stall(stall[0]), .pending_count(pending_count[0])
    );

    rf_scoreboard #(.DATA_WIDTH(DW), .REG_COUNT(RC), .ZERO_REG(1), .BYPASS(0)) dut_nobyp (
        .clk(clk), .rst(rst),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_en2(rd_en2), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1[1]), .rd_data2(rd_data2[1]),
        .rd_ready1(rd_ready1[1]), .rd_ready2(rd_ready2[1]),
        .stall(stall[1]), .pending_count(pending_count[1])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] m_data(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 8'h00;
        if (byp && wb_en && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    function automatic logic m_ready(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b1;
        if (byp && wb_en && wb_addr == a) return 1'b1;
        return !mpend[a];
    endfunction

    function automatic exp_t model(input string tag, input bit byp);
        exp_t e;
        e.tag = tag;
        e.d1  = m_data(rd_addr1, byp);
        e.d2  = m_data(rd_addr2, byp);
        e.r1  = m_ready(rd_addr1, byp);
        e.r2  = m_ready(rd_addr2, byp);
        e.st  = (rd_en1 && !e.r1) || (rd_en2 && !e.r2);
        e.cnt = 4'd0;
        for (int i = 0; i < RC; i++) e.cnt = e.cnt + {3'b0, mpend[i]};
        return e;
    endfunction

    task automatic drive(input logic ie, input logic [AW-1:0] ia,
                         input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic e1, input logic [AW-1:0] a1,
                         input logic e2, input logic [AW-1:0] a2);
        issue_en = ie; issue_addr = ia;
        wb_en = we; wb_addr = wa; wb_data = wd;
        rd_en1 = e1; rd_addr1 = a1; rd_en2 = e2; rd_addr2 = a2;
    endtask

    // Called just after a falling edge with inputs driven; returns after the next falling edge.
    task automatic step(input string tag);
        exp_t e;
        if (rst) begin
            for (int i = 0; i < RC; i++) mregs[i] = '0;
            mpend = '0;
        end
        sb.push_back(model(tag, 1'b1));
        sb.push_back(model(tag, 1'b0));
        #2;
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            chk($sformatf("%s[%0d].d1", e.tag, k),  rd_data1[k],      e.d1);
            chk($sformatf("%s[%0d].d2", e.tag, k),  rd_data2[k],      e.d2);
            chk($sformatf("%s[%0d].r1", e.tag, k),  rd_ready1[k],     e.r1);
            chk($sformatf("%s[%0d].r2", e.tag, k),  rd_ready2[k],     e.r2);
            chk($sformatf("%s[%0d].st", e.tag, k),  stall[k],         e.st);
            chk($sformatf("%s[%0d].cnt", e.tag, k), pending_count[k], e.cnt);
        end
        @(posedge clk);
        if (!rst) begin
            if (wb_en && wb_addr != 0) begin
                mregs[wb_addr] = wb_data;
                mpend[wb_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 0) mpend[issue_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < RC; i++) mregs[i] = '0;
        mpend = '0;
        @(negedge clk);

        // Reset state
        drive(0, 0, 0, 0, 0, 1, 3, 1, 5);
        #1;
        chk("reset.cnt", pending_count[0], 0);
        chk("reset.stall", stall[0], 0);
        chk("reset.rdy1", rd_ready1[0], 1);
        chk("reset.data1", rd_data1[0], 0);
        step("reset");
        rst = 1'b0;

        // Basic writeback and readback
        drive(0, 0, 1, 3, 8'hA5, 0, 3, 0, 0);
        step("wb3");
        drive(0, 0, 0, 0, 0, 1, 3, 0, 0);
        #1;
        chk("rd3.data1", rd_data1[0], 8'hA5);
        chk("rd3.rdy1", rd_ready1[0], 1);
        chk("rd3.cnt", pending_count[0], 0);
        step("rd3");

        // Issue, hazard, forwarded resolution
        drive(1, 5, 0, 0, 0, 1, 5, 0, 0);
        step("iss5_same_cycle");
        drive(0, 0, 0, 0, 0, 1, 5, 0, 0);
        #1;
        chk("haz5.rdy1", rd_ready1[0], 0);
        chk("haz5.stall", stall[0], 1);
        chk("haz5.cnt", pending_count[0], 1);
        step("haz5");
        drive(0, 0, 1, 5, 8'h3C, 1, 5, 1, 5);
        #1;
        chk("fwd5.data1", rd_data1[0], 8'h3C);
        chk("fwd5.rdy1", rd_ready1[0], 1);
        chk("fwd5.stall", stall[0], 0);
        chk("nofwd5.stall", stall[1], 1);
        step("fwd5");
        drive(0, 0, 0, 0, 0, 1, 5, 0, 0);
        #1;
        chk("post5.cnt", pending_count[0], 0);
        step("post5");

        // Same-cycle issue and writeback to one register: issue wins
        drive(1, 2, 1, 2, 8'h11, 0, 0, 0, 0);
        step("iss_wb2");
        drive(0, 0, 0, 0, 0, 1, 2, 1, 2);
        #1;
        chk("rd2.data1", rd_data1[0], 8'h11);
        chk("rd2.rdy1", rd_ready1[0], 0);
        chk("rd2.cnt", pending_count[0], 1);
        step("rd2");

        // Zero register ignores writes and issues
        drive(1, 0, 1, 0, 8'hFF, 1, 0, 1, 0);
        step("zero_wr");
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0);
        #1;
        chk("zero.data1", rd_data1[0], 0);
        chk("zero.rdy1", rd_ready1[0], 1);
        chk("zero.cnt", pending_count[0], 1);
        step("zero_rd");

        // Non-bypass instance sees old data on a same-cycle writeback
        drive(1, 4, 1, 2, 8'h22, 0, 0, 0, 0);
        step("iss4");
        drive(0, 0, 1, 4, 8'h77, 0, 0, 1, 4);
        #1;
        chk("nobyp4.data2", rd_data2[1], 8'h00);
        chk("nobyp4.rdy2", rd_ready2[1], 0);
        chk("byp4.data2", rd_data2[0], 8'h77);
        step("wb4");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 4);
        #1;
        chk("nobyp4n.data2", rd_data2[1], 8'h77);
        chk("nobyp4n.rdy2", rd_ready2[1], 1);
        step("rd4");

        // Issue every nonzero register, then reissue one
        for (int i = 1; i < RC; i++) begin
            drive(1, AW'(i), 0, 0, 0, 0, 0, 0, 0);
            step($sformatf("fill%0d", i));
        end
        drive(1, 1, 0, 0, 0, 1, 7, 1, 6);
        #1;
        chk("full.cnt", pending_count[0], 7);
        step("reissue1");
        drive(0, 0, 0, 0, 0, 1, 5, 0, 0);
        #1;
        chk("full2.cnt", pending_count[1], 7);

        // Asynchronous reset mid-cycle with an in-flight issue
        rst = 1'b1;
        drive(1, 6, 0, 0, 0, 1, 5, 1, 3);
        #1;
        chk("arst.cnt", pending_count[0], 0);
        chk("arst.rdy1", rd_ready1[0], 1);
        chk("arst.stall", stall[0], 0);
        chk("arst.data2", rd_data2[0], 0);
        step("arst");
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 6, 1, 3);
        #1;
        chk("post_rst.rdy1", rd_ready1[0], 1);
        chk("post_rst.cnt", pending_count[0], 0);
        step("post_rst");

        // Random traffic against the model
        for (int n = 0; n < 40; n++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, RC - 1)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, RC - 1)), DW'($urandom),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, RC - 1)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, RC - 1)));
            step($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
